// File: rtl/demux_deserializer_pkg.sv
// Shared sizing defaults and frame word type for the 1-to-8 demux deserializer.
package demux_deserializer_pkg;

    localparam int DEF_N_CH  = 8;
    localparam int DEF_SEL_W = $clog2(DEF_N_CH);
    localparam int DEF_CNT_W = 8;

    // Index 0 holds the first bit of a frame, matching the mux select order.
    typedef logic [0:DEF_N_CH-1] frame_t;

endpackage

// File: rtl/demux_deserializer_chan_decoder.sv
// One-hot slot write-enable decode of the channel counter, gated by accept.
module demux_deserializer_chan_decoder
    import demux_deserializer_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [0:N_CH-1]  we
);

    always_comb begin
        we = '0;
        for (int i = 0; i < N_CH; i++) begin
            we[i] = en && (sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/demux_deserializer.sv
// Receive end of the 8:1 TDM mux: assembles serial bits into a word and hands it off on valid/ready.
module demux_deserializer
    import demux_deserializer_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int SEL_W = DEF_SEL_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             frame_sync,
    output logic [0:N_CH-1]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] ch,
    output logic [CNT_W-1:0] word_cnt
);

    logic [SEL_W-1:0] ch_q, ch_d;
    logic [0:N_CH-1]  asm_q, asm_d;
    logic [0:N_CH-1]  out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    logic             ch_last;
    logic             accept;
    logic             frame_done;
    logic             handoff;
    logic [0:N_CH-1]  slot_we;
    logic [0:N_CH-1]  done_word;

    // Only the completing bit can stall: earlier slots never touch the output register.
    assign ch_last    = (ch_q == SEL_W'(N_CH - 1));
    assign in_ready   = !frame_sync && !(ch_last && out_valid_q && !out_ready);
    assign accept     = in_valid && in_ready;
    assign frame_done = accept && ch_last;
    assign handoff    = out_valid_q && out_ready;
    assign done_word  = {asm_q[0:N_CH-2], d_in};

    demux_deserializer_chan_decoder #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_chan_decoder (
        .sel (ch_q),
        .en  (accept),
        .we  (slot_we)
    );

    always_comb begin
        ch_d = ch_q;
        if (frame_sync) begin
            ch_d = '0;
        end else if (accept) begin
            ch_d = ch_last ? '0 : ch_q + SEL_W'(1);
        end
    end

    always_comb begin
        asm_d = asm_q;
        if (frame_sync || frame_done) begin
            asm_d = '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (slot_we[i]) begin
                    asm_d[i] = d_in;
                end
            end
        end
    end

    // A completing frame wins over a drain so a simultaneous drain+load keeps out_valid high.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        word_cnt_d  = word_cnt_q;
        if (handoff) begin
            out_valid_d = 1'b0;
            word_cnt_d  = word_cnt_q + CNT_W'(1);
        end
        if (frame_done) begin
            out_data_d  = done_word;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q        <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            ch_q        <= ch_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign ch        = ch_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign word_cnt  = word_cnt_q;

endmodule
